// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receiver (LSB first, idle-high line).
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit time (even, >= 4); must match the transmitter
//   SYNC_STAGES   flops in the i_rx metastability synchronizer (>= 2)
//
// Ports
//   clk              system clock, all logic on posedge
//   i_reset          asynchronous, active-high reset
//   i_rx             serial input line, asynchronous to clk, idle high
//   o_data           last good byte, held until the next good frame
//   o_data_valid     1-cycle strobe, o_data updated with a good frame
//   o_framing_error  1-cycle strobe, stop bit sampled low, byte discarded
//   o_busy           high while a frame is in progress (state != IDLE)
//
// Handshake: there is no backpressure. o_data_valid is a single-cycle strobe
// and the consumer must capture o_data in that cycle (o_data also stays
// stable until the next good frame).
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    output logic       o_framing_error,
    output logic       o_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev;
    logic [CNT_W-1:0]       clk_cnt, clk_cnt_next;
    logic [2:0]             bit_idx, bit_idx_next;
    logic [7:0]             shift, shift_next;
    logic [7:0]             data_next;
    logic                   valid_next;
    logic                   ferr_next;

    // Synchronizer resets to the idle level so reset release never looks
    // like a start edge.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], i_rx};
            rx_prev <= rx_s;
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        data_next    = o_data;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;

        case (state)
            IDLE: begin
                clk_cnt_next = '0;
                // Edge detect, not level: a line stuck low (break) cannot
                // retrigger until it has gone high again.
                if (rx_prev && !rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_next = '0;
                    if (!rx_s) begin
                        state_next   = DATA;
                        bit_idx_next = 3'd0;
                    end else begin
                        // Line back high at mid start bit: glitch, drop it.
                        state_next = IDLE;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (clk_cnt == FULL_LAST) begin
                    clk_cnt_next        = '0;
                    shift_next[bit_idx] = rx_s;
                    bit_idx_next        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (clk_cnt == FULL_LAST) begin
                    // Leaving at mid stop bit leaves half a bit of slack to
                    // catch a back-to-back start edge.
                    clk_cnt_next = '0;
                    state_next   = IDLE;
                    if (rx_s) begin
                        data_next  = shift;
                        valid_next = 1'b1;
                    end else begin
                        ferr_next = 1'b1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                clk_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state           <= IDLE;
            clk_cnt         <= '0;
            bit_idx         <= 3'd0;
            shift           <= 8'h00;
            o_data          <= 8'h00;
            o_data_valid    <= 1'b0;
            o_framing_error <= 1'b0;
        end else begin
            state           <= state_next;
            clk_cnt         <= clk_cnt_next;
            bit_idx         <= bit_idx_next;
            shift           <= shift_next;
            o_data          <= data_next;
            o_data_valid    <= valid_next;
            o_framing_error <= ferr_next;
        end
    end

    assign o_busy = (state != IDLE);

endmodule
